pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload data width in bits (minimum 1).
REQ-002 Parameter CTRL_W, default 4, SHALL set the control-bit width, e.g. wb/mem-read/mem-write bits (minimum 1).
REQ-003 Parameter CLEAR_DATA, default 0, SHALL, when 1, zero out_data whenever out_valid is 0.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state SHALL update on the rising edge only.
REQ-005 Port startin, input, 1, SHALL be the reset: asynchronous and active-low (0 = reset).
REQ-006 Port in_valid, input, 1, SHALL mark the upstream stage as presenting a valid entry.
REQ-007 Port in_ready, output, 1, SHALL mark this stage as able to accept an entry.
REQ-008 Port in_ctrl, input, CTRL_W, SHALL carry the upstream control bits.
REQ-009 Port in_data, input, DATA_W, SHALL carry the upstream payload (ALU result, store data, dest reg, packed).
REQ-010 Port flush, input, 1, SHALL be a synchronous request to discard all held entries.
REQ-011 Port out_valid, output, 1, SHALL mark a valid entry presented downstream.
REQ-012 Port out_ready, input, 1, SHALL mark the downstream stage as able to take the entry.
REQ-013 Port out_ctrl, output, CTRL_W, SHALL carry the control bits of the head entry.
REQ-014 Port out_data, output, DATA_W, SHALL carry the payload of the head entry.
REQ-015 Port occupancy, output, 2, SHALL report held entries: 0, 1 or 2.

Function
REQ-016 The block SHALL hold a main register and a skid register, sequenced by states EMPTY (0), ONE (1) and FULL (2); occupancy SHALL equal the state encoding.
REQ-017 in_fire SHALL be in_valid & in_ready; out_fire SHALL be out_valid & out_ready.
REQ-018 in_ready SHALL be (state != FULL) decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-019 out_valid SHALL be (state != EMPTY); out_ctrl/out_data SHALL always come from the main register.
REQ-020 EMPTY: in_fire SHALL load main and go to ONE; otherwise remain EMPTY.
REQ-021 ONE: in_fire & !out_fire SHALL load skid and go FULL; in_fire & out_fire SHALL load main and stay ONE; !in_fire & out_fire SHALL go EMPTY; neither SHALL hold.
REQ-022 FULL: out_fire SHALL copy skid into main and go ONE; otherwise hold; in_fire cannot occur.
REQ-023 Latency SHALL be exactly one cycle from in_fire to out_valid when EMPTY; entries SHALL leave in acceptance order, none dropped or duplicated.
REQ-024 Sustained in_valid=1/out_ready=1 SHALL give one entry per cycle throughput.
REQ-025 flush=1 SHALL force next state EMPTY, overriding all transitions; an input presented in the flush cycle SHALL be discarded.
REQ-026 Whenever out_valid=0, out_ctrl SHALL be all zeros (bubble/NOP); out_data SHALL hold its last value unless CLEAR_DATA=1, then zero.
REQ-027 in_ctrl/in_data SHALL be ignored when in_fire=0; registers SHALL not change on non-fire cycles.
REQ-028 occupancy SHALL never exceed 2; out_valid with out_ready=0 SHALL keep out_ctrl/out_data stable.

Reset
REQ-029 startin=0 SHALL immediately, without waiting for clk, set state EMPTY and zero both registers: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all held entries; the first edge after startin returns to 1 SHALL behave as from EMPTY.

Verification
REQ-031 Reset then in_valid=1, in_ctrl=4'hA, in_data=32'h1234 for one cycle, out_ready=1 -> next cycle out_valid=1, out_ctrl=A, out_data=1234, occupancy=1; following cycle out_valid=0, out_ctrl=0.
REQ-032 out_ready=0, accept D0=0x11 then D1=0x22 -> occupancy=2, in_ready=0, out_data=0x11 held; release out_ready -> 0x11 then 0x22 on consecutive cycles, then EMPTY.
REQ-033 Continuous stream 0x1..0x10 with out_ready=1 -> 16 outputs on 16 consecutive cycles in order, occupancy stays 1.
REQ-034 FULL, flush=1 with in_valid=1 data 0x99 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x99 never appears on out_data.
REQ-035 Random in_valid/out_ready (10k cycles) against a reference queue -> identical in-order sequence, no loss, in_ready never 1 while FULL.
REQ-036 startin pulsed low between clock edges while FULL -> outputs zero before next edge; normal operation resumes after release.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush and registered-only ready.
module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 4,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  logic [1:0]        state, state_nx;
  logic              in_fire, out_fire, ld_main, ld_skid, mv_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) state <= EMPTY;
    else          state <= state_nx;
  end
  // flush wins over every transition and suppresses all register loads
  always_comb begin
    state_nx = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    mv_skid  = 1'b0;
    case (state)
      EMPTY: begin
        ld_main  = in_fire;
        state_nx = in_fire ? ONE : EMPTY;
      end
      ONE: begin
        ld_main  = in_fire & out_fire;
        ld_skid  = in_fire & ~out_fire;
        state_nx = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : ONE;
      end
      FULL: begin
        mv_skid  = out_fire;
        state_nx = out_fire ? ONE : FULL;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      ld_main  = 1'b0;
      ld_skid  = 1'b0;
      mv_skid  = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      main_ctrl <= mv_skid ? skid_ctrl : ld_main ? in_ctrl : main_ctrl;
      main_data <= mv_skid ? skid_data : ld_main ? in_data : main_data;
      skid_ctrl <= ld_skid ? in_ctrl : skid_ctrl;
      skid_data <= ld_skid ? in_data : skid_data;
    end
  end
  always_comb begin
    in_ready  = state != FULL;
    out_valid = state != EMPTY;
    out_ctrl  = out_valid ? main_ctrl : '0;
    out_data  = (CLEAR_DATA && !out_valid) ? '0 : main_data;
    occupancy = state;
  end
endmodule
